// File: rtl/mult_wb_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_wb_merge_pkg
// Brief    : Shared register-file sizes and writeback-entry type for the
//            multiply writeback merge.
// Revision : 1.0 - initial release
// ============================================================================
package mult_wb_merge_pkg;

  localparam int REG_SIZE = 32;
  localparam int REG_ADDR = 5;

  typedef struct packed {
    logic                live;
    logic [REG_ADDR-1:0] dst;
    logic [REG_SIZE-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mult_wb_merge_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Multiply holding FIFO with per-entry kill-by-address and a live
//            destination match used for hazard queries.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import mult_wb_merge_pkg::*;
#(
  parameter int DATA_W = REG_SIZE,
  parameter int ADDR_W = REG_ADDR,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              push_live,
  input  logic              push_exc,
  input  logic [ADDR_W-1:0] push_dst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_dst,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              head_live,
  output logic              head_exc,
  output logic [ADDR_W-1:0] head_dst,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              chk_match
);

  logic              r_live [DEPTH];
  logic              r_exc  [DEPTH];
  logic [ADDR_W-1:0] r_dst  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_live[i] <= 1'b0;
        r_exc[i]  <= 1'b0;
        r_dst[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Kill first so a push into the free slot is never affected by it.
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_dst[i] == kill_dst) r_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_exc[r_rd_ptr]  <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end
      if (push) begin
        r_live[r_wr_ptr] <= push_live;
        r_exc[r_wr_ptr]  <= push_exc;
        r_dst[r_wr_ptr]  <= push_dst;
        r_data[r_wr_ptr] <= push_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  always_comb begin
    chk_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_dst[i] == chk_reg)) chk_match = 1'b1;
    end
  end

  assign head_live = r_live[r_rd_ptr];
  assign head_exc  = r_exc[r_rd_ptr];
  assign head_dst  = r_dst[r_rd_ptr];
  assign head_data = r_data[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mult_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : mult_wb_merge
// Brief    : Merges multiply and ALU writebacks onto one register-file port,
//            ALU first; optional overflow trap via MUL_OVF_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_wb_merge
  import mult_wb_merge_pkg::*;
#(
  parameter int DATA_W = REG_SIZE,
  parameter int ADDR_W = REG_ADDR,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mul_valid,
  input  logic [ADDR_W-1:0] mul_dst,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              mul_overflow,
  output logic              mul_stall,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              chk_pending,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mul_exc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              w_ovf_trap;
  logic              w_accept;
  logic              w_alu_kill;
  logic              w_mul_live;
  logic              w_push;
  logic              w_pop;
  logic              w_we;
  logic              w_exc;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  logic              w_head_live;
  logic              w_head_exc;
  logic [ADDR_W-1:0] w_head_dst;
  logic [DATA_W-1:0] w_head_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;

  logic              r_we;
  logic              r_exc;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

`ifdef MUL_OVF_TRAP_EN
  assign w_ovf_trap = mul_overflow;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = mul_overflow;
  assign w_ovf_trap   = 1'b0;
`endif

  assign mul_stall  = (w_count == CNT_W'(DEPTH));
  assign w_accept   = mul_valid && !mul_stall && (mul_dst != '0);
  // The ALU op is younger than every multiply result still in flight.
  assign w_alu_kill = alu_valid && (alu_dst != '0);
  assign w_mul_live = !w_ovf_trap && !(w_alu_kill && (mul_dst == alu_dst));

  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_we    = 1'b0;
    w_exc   = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (alu_valid) begin
      w_push  = w_accept;
      w_we    = (alu_dst != '0);
      w_waddr = alu_dst;
      w_wdata = alu_data;
    end else if (!w_empty) begin
      w_push  = w_accept;
      w_pop   = 1'b1;
      w_we    = w_head_live;
      w_exc   = w_head_exc;
      w_waddr = w_head_dst;
      w_wdata = w_head_data;
    end else begin
      w_we    = w_accept && w_mul_live;
      w_exc   = w_accept && w_ovf_trap;
      w_waddr = mul_dst;
      w_wdata = mul_data;
    end
  end

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_live (w_mul_live),
    .push_exc  (w_ovf_trap),
    .push_dst  (mul_dst),
    .push_data (mul_data),
    .pop       (w_pop),
    .kill_en   (w_alu_kill),
    .kill_dst  (alu_dst),
    .chk_reg   (chk_reg),
    .head_live (w_head_live),
    .head_exc  (w_head_exc),
    .head_dst  (w_head_dst),
    .head_data (w_head_data),
    .count     (w_count),
    .empty     (w_empty),
    .chk_match (chk_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_exc   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we    <= w_we;
      r_exc   <= w_exc;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign mul_exc  = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_mult_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_wb_merge
// Brief    : Directed self-checking bench for mult_wb_merge (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_wb_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        mul_valid;
  logic [4:0]  mul_dst;
  logic [31:0] mul_data;
  logic        mul_overflow;
  logic        mul_stall;
  logic [4:0]  chk_reg;
  logic        chk_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mul_exc;

  int errors = 0;
  int checks = 0;

  mult_wb_merge #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_dst      (alu_dst),
    .alu_data     (alu_data),
    .mul_valid    (mul_valid),
    .mul_dst      (mul_dst),
    .mul_data     (mul_data),
    .mul_overflow (mul_overflow),
    .mul_stall    (mul_stall),
    .chk_reg      (chk_reg),
    .chk_pending  (chk_pending),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mul_exc      (mul_exc)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                       input logic ovf);
    alu_valid = av; alu_dst = ad; alu_data = adat;
    mul_valid = mv; mul_dst = md; mul_data = mdat; mul_overflow = ovf;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    chk_reg = 5'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mul_exc} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h exc=%b, want all zero",
               rf_we, rf_waddr, rf_wdata, mul_exc);
    end
    checks++;
    if (mul_stall !== 1'b0 || chk_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got stall=%b pending=%b, want 0 0", mul_stall, chk_pending);
    end
  endtask

  task automatic test_direct();
    chk_reg = 5'd5;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL direct_write: got we=%b addr=%0d data=%h, want 1 5 12345678",
               rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (chk_pending !== 1'b0 || mul_stall !== 1'b0) begin
      errors++;
      $display("FAIL direct_empty: got pending=%b stall=%b, want 0 0", chk_pending, mul_stall);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(16 + i), 32'hC000_0000 + 32'(i), 1'b0);
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(16 + i) || rf_wdata !== 32'hC000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h, want 1 %0d %h",
                 i, rf_we, rf_waddr, rf_wdata, 16 + i, 32'hC000_0000 + 32'(i));
      end
    end
    idle();
    tick();
  endtask

  task automatic test_conflict();
    chk_reg = 5'd4;
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA) begin
      errors++;
      $display("FAIL conflict_alu: got we=%b addr=%0d data=%h, want 1 3 aaaa", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (chk_pending !== 1'b1) begin
      errors++;
      $display("FAIL conflict_pending: got %b, want 1", chk_pending);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBBBB) begin
      errors++;
      $display("FAIL conflict_mul: got we=%b addr=%0d data=%h, want 1 4 bbbb", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (chk_pending !== 1'b0) begin
      errors++;
      $display("FAIL conflict_drained: got pending=%b, want 0", chk_pending);
    end
  endtask

  task automatic test_full_stall();
    logic [4:0]  exp_addr [6];
    logic [31:0] exp_data [6];
    logic        exp_stall [6];
    exp_addr = '{5'd10, 5'd12, 5'd14, 5'd11, 5'd13, 5'd15};
    exp_data = '{32'hA1, 32'hA2, 32'hA3, 32'hB1, 32'hB2, 32'hB3};
    // Stall as seen while driving each cycle
    exp_stall = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 5'd10, 32'hA1, 1'b1, 5'd11, 32'hB1, 1'b0);
        1: drive(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hB2, 1'b0);
        2: drive(1'b1, 5'd14, 32'hA3, 1'b1, 5'd15, 32'hB3, 1'b0);
        3: drive(1'b0, 5'd0,  32'h0,  1'b1, 5'd15, 32'hB3, 1'b0);
        4: drive(1'b0, 5'd0,  32'h0,  1'b1, 5'd15, 32'hB3, 1'b0);
        default: idle();
      endcase
      #1;
      checks++;
      if (mul_stall !== exp_stall[c]) begin
        errors++;
        $display("FAIL full_stall_c%0d: got stall=%b, want %b", c, mul_stall, exp_stall[c]);
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr[c] || rf_wdata !== exp_data[c]) begin
        errors++;
        $display("FAIL full_write_c%0d: got we=%b addr=%0d data=%h, want 1 %0d %h",
                 c, rf_we, rf_waddr, rf_wdata, exp_addr[c], exp_data[c]);
      end
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || mul_stall !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: got we=%b stall=%b, want 0 0", rf_we, mul_stall);
    end
  endtask

  task automatic test_waw_kill();
    chk_reg = 5'd7;
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd7, 32'h1, 1'b0);
    tick();
    checks++;
    if (chk_pending !== 1'b1) begin
      errors++;
      $display("FAIL waw_pending_before: got %b, want 1", chk_pending);
    end
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2 || chk_pending !== 1'b0) begin
      errors++;
      $display("FAIL waw_alu: got we=%b addr=%0d data=%h pending=%b, want 1 7 2 0",
               rf_we, rf_waddr, rf_wdata, chk_pending);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL waw_dead_pop: got we=%b, want 0", rf_we);
    end
    // Same-cycle kill: multiply pushed dead behind the ALU write
    chk_reg = 5'd6;
    drive(1'b1, 5'd6, 32'h10, 1'b1, 5'd6, 32'h20, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'h10 || chk_pending !== 1'b0) begin
      errors++;
      $display("FAIL waw_same_alu: got we=%b data=%h pending=%b, want 1 10 0", rf_we, rf_wdata, chk_pending);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL waw_same_dead: got we=%b, want 0", rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || mul_stall !== 1'b0) begin
      errors++;
      $display("FAIL waw_settled: got we=%b stall=%b, want 0 0", rf_we, mul_stall);
    end
  endtask

  task automatic test_r0();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL r0_mul: got we=%b, want 0", rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || mul_stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_push: got we=%b stall=%b, want 0 0", rf_we, mul_stall);
    end
    drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL r0_alu: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_reset_midop();
    chk_reg = 5'd20;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 1'b0);
    tick();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21, 1'b0);
    tick();
    idle();
    checks++;
    if (mul_stall !== 1'b1 || chk_pending !== 1'b1) begin
      errors++;
      $display("FAIL midreset_full: got stall=%b pending=%b, want 1 1", mul_stall, chk_pending);
    end
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if (rf_we !== 1'b0 || mul_stall !== 1'b0 || chk_pending !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got we=%b stall=%b pending=%b, want 0 0 0",
               rf_we, mul_stall, chk_pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL midreset_nowrite%0d: got we=%b addr=%0d, want we=0", i, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1);
    tick();
    idle();
`ifdef MUL_OVF_TRAP_EN
    checks++;
    if (rf_we !== 1'b0 || mul_exc !== 1'b1) begin
      errors++;
      $display("FAIL ovf_trap: got we=%b exc=%b, want 0 1", rf_we, mul_exc);
    end
`else
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || mul_exc !== 1'b0) begin
      errors++;
      $display("FAIL ovf_write: got we=%b addr=%0d data=%h exc=%b, want 1 9 99 0",
               rf_we, rf_waddr, rf_wdata, mul_exc);
    end
`endif
    tick();
    checks++;
    if (mul_exc !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after: got exc=%b we=%b, want 0 0", mul_exc, rf_we);
    end
  endtask

  initial begin
    reset = 1'b1;
    chk_reg = 5'd0;
    idle();
    test_reset();
    test_direct();
    test_back_to_back();
    test_conflict();
    test_full_stall();
    test_waw_kill();
    test_r0();
    test_reset_midop();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
